// File: rtl/register_file_mp.sv
// Multi-port integer register file for decode: registered reads, optional
// write-to-read bypass and a per-register busy scoreboard for in-flight producers.

module register_file_mp_rd_port #(
  parameter int W      = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [AW-1:0]         addr,
  input  logic [DEPTH-1:0][W-1:0] regs_q,
  input  logic [DEPTH-1:0][W-1:0] regs_d,
  input  logic [DEPTH-1:0]      busy_d,
  output logic [W-1:0]          data,
  output logic                  busy
);
  logic hit;

  // x0 and out-of-range addresses read as zero and never busy
  assign hit = (addr != '0) && (32'(addr) < DEPTH);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      data <= !hit ? '0 : ((BYPASS != 0) ? regs_d[addr] : regs_q[addr]);
      busy <= hit && busy_d[addr];
    end
  end
endmodule

module register_file_mp #(
  parameter int          REGISTER_WIDTH    = 32,
  parameter int          REGISTER_DEPTH    = 32,
  parameter int          READ_PORTS        = 2,
  parameter int          WRITE_PORTS       = 1,
  parameter int          STACK_POINTER_ADD = 2,
  parameter logic [31:0] STACK_POINTER_VAL = 32'd1024,
  parameter int          BYPASS            = 1,
  localparam int         A = (REGISTER_DEPTH > 1) ? $clog2(REGISTER_DEPTH) : 1
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic [READ_PORTS*A-1:0]             RS_ADDRESS,
  output logic [READ_PORTS*REGISTER_WIDTH-1:0] RS_DATA,
  output logic [READ_PORTS-1:0]               RS_BUSY,
  input  logic [WRITE_PORTS*A-1:0]            RD_ADDRESS,
  input  logic [WRITE_PORTS*REGISTER_WIDTH-1:0] RD_DATA,
  input  logic [WRITE_PORTS-1:0]              RD_WRITE_EN,
  input  logic [A-1:0]                        ISSUE_ADDRESS,
  input  logic                                ISSUE_EN,
  input  logic                                FLUSH
);
  localparam int W = REGISTER_WIDTH;
  localparam int D = REGISTER_DEPTH;

  typedef struct packed {
    logic         en;
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } wr_req_t;

  wr_req_t [WRITE_PORTS-1:0] wr;
  logic [D-1:0][W-1:0]       regs_q, regs_d;
  logic [D-1:0]              busy_q, busy_d;

  function automatic logic writable(input logic [A-1:0] a);
    return (a != '0) && (32'(a) < D);
  endfunction

  for (genvar j = 0; j < WRITE_PORTS; j++) begin : g_wr
    assign wr[j] = {RD_WRITE_EN[j], RD_ADDRESS[j*A +: A], RD_DATA[j*W +: W]};
  end

  // Ascending port order lets the highest-indexed writer win a collision
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (wr[j].en && writable(wr[j].addr)) begin
        regs_d[wr[j].addr] = wr[j].data;
        busy_d[wr[j].addr] = 1'b0;
      end
    end
    // A fresh issue supersedes the retiring producer; flush overrides both
    if (ISSUE_EN && writable(ISSUE_ADDRESS)) busy_d[ISSUE_ADDRESS] = 1'b1;
    if (FLUSH) busy_d = '0;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < D; i++)
        regs_q[i] <= (i == STACK_POINTER_ADD && i != 0) ? W'(STACK_POINTER_VAL) : '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    register_file_mp_rd_port #(
      .W(W), .DEPTH(D), .AW(A), .BYPASS(BYPASS)
    ) u_rd (
      .CLK   (CLK),
      .RST_N (RST_N),
      .addr  (RS_ADDRESS[k*A +: A]),
      .regs_q(regs_q),
      .regs_d(regs_d),
      .busy_d(busy_d),
      .data  (RS_DATA[k*W +: W]),
      .busy  (RS_BUSY[k])
    );
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: dut_a (4 read, 2 write, bypass) and dut_b (2 read, 1 write, no bypass).

module tb_register_file_mp;
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [3:0][4:0]  a_ra;
  logic [127:0]     a_data;
  logic [3:0]       a_busy;
  logic [1:0][4:0]  a_wa;
  logic [1:0][31:0] a_wd;
  logic [1:0]       a_we;
  logic [4:0]       a_iss_a;
  logic             a_iss_en, a_flush;

  logic [1:0][4:0]  b_ra;
  logic [63:0]      b_data;
  logic [1:0]       b_busy;
  logic [4:0]       b_wa;
  logic [31:0]      b_wd;
  logic             b_we;
  logic [4:0]       b_iss_a;
  logic             b_iss_en, b_flush;

  register_file_mp #(.READ_PORTS(4), .WRITE_PORTS(2), .BYPASS(1)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .RS_ADDRESS(a_ra), .RS_DATA(a_data), .RS_BUSY(a_busy),
    .RD_ADDRESS(a_wa), .RD_DATA(a_wd), .RD_WRITE_EN(a_we),
    .ISSUE_ADDRESS(a_iss_a), .ISSUE_EN(a_iss_en), .FLUSH(a_flush));

  register_file_mp #(.READ_PORTS(2), .WRITE_PORTS(1), .BYPASS(0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .RS_ADDRESS(b_ra), .RS_DATA(b_data), .RS_BUSY(b_busy),
    .RD_ADDRESS(b_wa), .RD_DATA(b_wd), .RD_WRITE_EN(b_we),
    .ISSUE_ADDRESS(b_iss_a), .ISSUE_EN(b_iss_en), .FLUSH(b_flush));

  typedef struct packed {
    int          cyc;
    logic        dut;
    logic [1:0]  port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, act, ex);
    end
  endtask

  // Expectation for the next posedge
  task automatic push(input string n, input bit d, input int p, input logic [31:0] v,
                      input logic b);
    exp_t e;
    e.cyc = cyc + 1; e.dut = d; e.port = p[1:0]; e.data = v; e.busy = b;
    q.push_back(e);
    qn.push_back(n);
  endtask

  task automatic reset_zero(input string n);
    for (int k = 0; k < 4; k++) begin
      check({n, "_a_data"}, a_data[k*32 +: 32], 32'h0);
      check({n, "_a_busy"}, 32'(a_busy[k]), 32'h0);
    end
    for (int k = 0; k < 2; k++) begin
      check({n, "_b_data"}, b_data[k*32 +: 32], 32'h0);
      check({n, "_b_busy"}, 32'(b_busy[k]), 32'h0);
    end
  endtask

  task automatic idle();
    a_we = '0; a_iss_en = 1'b0; a_flush = 1'b0;
    b_we = 1'b0; b_iss_en = 1'b0; b_flush = 1'b0;
  endtask

  // Monitor: outputs are valid every cycle, so compare everything due at this edge
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n = qn.pop_front();
        if (e.dut) begin
          check({n, "_data"}, b_data[int'(e.port)*32 +: 32], e.data);
          check({n, "_busy"}, 32'(b_busy[e.port]), 32'(e.busy));
        end else begin
          check({n, "_data"}, a_data[int'(e.port)*32 +: 32], e.data);
          check({n, "_busy"}, 32'(a_busy[e.port]), 32'(e.busy));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    RST_N = 1'b0;
    a_wa = '0; a_wd = '0; a_iss_a = '0; b_wa = '0; b_wd = '0; b_iss_a = '0;
    idle();
    a_ra = {5'd0, 5'd5, 5'd2, 5'd0};
    b_ra = {5'd2, 5'd5};
    #2 reset_zero("rst_async");
    @(negedge CLK);
    reset_zero("rst_edge");
    RST_N = 1'b1;
    push("rst_x0", 0, 0, 32'h0, 1'b0);
    push("rst_sp", 0, 1, 32'd1024, 1'b0);
    push("rst_x5", 0, 2, 32'h0, 1'b0);
    push("rst_b_x5", 1, 0, 32'h0, 1'b0);
    push("rst_b_sp", 1, 1, 32'd1024, 1'b0);

    // write x5 with a same-edge read
    @(negedge CLK); idle();
    a_we[0] = 1'b1; a_wa[0] = 5'd5; a_wd[0] = 32'hDEADBEEF; a_ra[0] = 5'd5;
    b_we = 1'b1; b_wa = 5'd5; b_wd = 32'hDEADBEEF; b_ra[0] = 5'd5;
    push("byp_wr", 0, 0, 32'hDEADBEEF, 1'b0);
    push("nobyp_old", 1, 0, 32'h0, 1'b0);
    @(negedge CLK); idle();
    push("byp_hold", 0, 0, 32'hDEADBEEF, 1'b0);
    push("nobyp_new", 1, 0, 32'hDEADBEEF, 1'b0);

    // x0 immunity: writes and issues to x0
    @(negedge CLK); idle();
    a_we = 2'b11; a_wa[0] = 5'd0; a_wa[1] = 5'd0; a_wd[0] = '1; a_wd[1] = '1;
    a_iss_en = 1'b1; a_iss_a = 5'd0;
    a_ra[0] = 5'd0; a_ra[1] = 5'd0; a_ra[2] = 5'd5;
    b_we = 1'b1; b_wa = 5'd0; b_wd = '1; b_iss_en = 1'b1; b_iss_a = 5'd0; b_ra[0] = 5'd0;
    push("x0_p0", 0, 0, 32'h0, 1'b0);
    push("x0_p1", 0, 1, 32'h0, 1'b0);
    push("x5_keep", 0, 2, 32'hDEADBEEF, 1'b0);
    push("b_x0", 1, 0, 32'h0, 1'b0);
    @(negedge CLK); idle();
    push("x0_after", 0, 0, 32'h0, 1'b0);
    push("b_x0_after", 1, 0, 32'h0, 1'b0);

    // dual-write conflict on x7
    @(negedge CLK); idle();
    a_we = 2'b11; a_wa[0] = 5'd7; a_wa[1] = 5'd7; a_wd[0] = 32'h11; a_wd[1] = 32'h22;
    a_ra[0] = 5'd7;
    push("dual_byp", 0, 0, 32'h22, 1'b0);
    @(negedge CLK); idle();
    push("dual_hold", 0, 0, 32'h22, 1'b0);

    // scoreboard: issue x9, retire it three edges later
    @(negedge CLK); idle();
    a_iss_en = 1'b1; a_iss_a = 5'd9; a_ra[0] = 5'd9;
    b_iss_en = 1'b1; b_iss_a = 5'd9; b_ra[0] = 5'd9;
    push("issue_x9", 0, 0, 32'h0, 1'b1);
    push("b_issue_x9", 1, 0, 32'h0, 1'b1);
    repeat (2) begin
      @(negedge CLK); idle();
      push("busy_hold", 0, 0, 32'h0, 1'b1);
      push("b_busy_hold", 1, 0, 32'h0, 1'b1);
    end
    @(negedge CLK); idle();
    a_we[1] = 1'b1; a_wa[1] = 5'd9; a_wd[1] = 32'h99;
    b_we = 1'b1; b_wa = 5'd9; b_wd = 32'h99;
    push("retire_x9", 0, 0, 32'h99, 1'b0);
    push("b_retire_x9", 1, 0, 32'h0, 1'b0);

    // issue and write x9 on one edge: busy stays set
    @(negedge CLK); idle();
    a_we[0] = 1'b1; a_wa[0] = 5'd9; a_wd[0] = 32'hAA; a_iss_en = 1'b1; a_iss_a = 5'd9;
    push("iss_wr_same", 0, 0, 32'hAA, 1'b1);
    push("b_x9_late", 1, 0, 32'h99, 1'b0);

    @(negedge CLK); idle();
    a_iss_en = 1'b1; a_iss_a = 5'd4; a_ra[0] = 5'd4; a_ra[1] = 5'd9;
    push("issue_x4", 0, 0, 32'h0, 1'b1);
    push("x9_still", 0, 1, 32'hAA, 1'b1);

    // flush swallows a same-cycle issue
    @(negedge CLK); idle();
    a_flush = 1'b1; a_iss_en = 1'b1; a_iss_a = 5'd6;
    a_ra = {5'd7, 5'd6, 5'd9, 5'd4};
    push("flush_x4", 0, 0, 32'h0, 1'b0);
    push("flush_x9", 0, 1, 32'hAA, 1'b0);
    push("flush_x6", 0, 2, 32'h0, 1'b0);
    push("flush_x7", 0, 3, 32'h22, 1'b0);

    // all four ports alternate x2/x3 while x3 is rewritten each cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); idle();
      a_we[i % 2] = 1'b1; a_wa[i % 2] = 5'd3; a_wd[i % 2] = 32'h100 + 32'(i);
      for (int k = 0; k < 4; k++) begin
        a = ((i + k) % 2 == 0) ? 2 : 3;
        a_ra[k] = 5'(a);
        push("rport", 0, k, (a == 2) ? 32'd1024 : 32'h100 + 32'(i), 1'b0);
      end
    end

    @(negedge CLK); idle();
    a_iss_en = 1'b1; a_iss_a = 5'd5; a_ra[0] = 5'd5;
    push("issue_x5", 0, 0, 32'hDEADBEEF, 1'b1);

    // mid-cycle reset wipes data, busy and outputs
    @(posedge CLK); #3;
    idle();
    RST_N = 1'b0;
    #1 reset_zero("rst_mid");
    @(negedge CLK);
    @(negedge CLK);
    reset_zero("rst_mid_edge");
    a_ra = {5'd3, 5'd0, 5'd2, 5'd5};
    b_ra = {5'd2, 5'd9};
    RST_N = 1'b1;
    push("post_rst_x5", 0, 0, 32'h0, 1'b0);
    push("post_rst_sp", 0, 1, 32'd1024, 1'b0);
    push("post_rst_x0", 0, 2, 32'h0, 1'b0);
    push("post_rst_x3", 0, 3, 32'h0, 1'b0);
    push("post_rst_b_x9", 1, 0, 32'h0, 1'b0);
    push("post_rst_b_sp", 1, 1, 32'd1024, 1'b0);

    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
